// File: rtl/cnt_seq_arb.sv
// cnt_seq_arb: round-robin arbiter and sequencer in front of a shared
// WIDTH-bit up/down counter. The granted requester's target is latched,
// and the counter is stepped along the shorter modular path until it
// lands on the target, after which a one-cycle done pulse is returned.
module cnt_seq_arb #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] tgt0,
    input  logic [WIDTH-1:0] tgt1,
    input  logic [WIDTH-1:0] cnt,
    output logic             en,
    output logic             up_dwn_n,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Half of the modular range; a distance of exactly this much counts up.
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q,   state_d;
    logic             ptr_q,     ptr_d;
    logic [WIDTH-1:0] tgt_lat_q, tgt_lat_d;
    logic [1:0]       gnt_q,     gnt_d;

    logic [WIDTH-1:0] diff;
    logic             at_tgt;
    logic             held;
    logic             pick;
    logic             gsel;

    // Distance to target, arbitration choice and hold status of the owner.
    always_comb begin
        diff   = tgt_lat_q - cnt;
        at_tgt = (diff == '0);
        held   = |(req & gnt_q);
        gsel   = gnt_q[1];
        pick   = (req == 2'b11) ? ptr_q : req[1];
    end

    // Next-state logic for the sequencer and round-robin pointer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tgt_lat_d = tgt_lat_q;
        gnt_d     = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d     = pick ? 2'b10 : 2'b01;
                    tgt_lat_d = pick ? tgt1 : tgt0;
                    state_d   = ST_MOVE;
                end
            end
            ST_MOVE: begin
                // An abandoned request wins over arrival on target.
                if (!held) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ~ptr_q;
                end else if (at_tgt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ~gsel;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, pointer, latched target and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            tgt_lat_q <= '0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tgt_lat_q <= tgt_lat_d;
            gnt_q     <= gnt_d;
        end
    end

    // Counter controls and status outputs, derived from registered state.
    always_comb begin
        en       = (state_q == ST_MOVE) && held && !at_tgt;
        up_dwn_n = (state_q != ST_MOVE) || (diff <= HALF);
        gnt      = gnt_q;
        done     = (state_q == ST_DONE) ? gnt_q : 2'b00;
        busy     = (state_q != ST_IDLE);
    end

    gnt_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    state_legal_a: assert property (@(posedge clk) disable iff (!rst_n) state_q != 2'd3);

endmodule

// File: tb/tb_cnt_seq_arb.sv
// Bench for cnt_seq_arb: a behavioural counter closes the loop, a
// transaction-level model predicts every output each cycle, and directed
// scenarios pin the model with literal expectations.
module tb_cnt_seq_arb;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [1:0] req    = 2'b00;
    logic [3:0] tgt0   = 4'd0;
    logic [3:0] tgt1   = 4'd0;
    logic [3:0] cnt_r  = 4'd0;
    logic       ld     = 1'b0;
    logic [3:0] ld_val = 4'd0;
    logic       en, up_dwn_n, busy;
    logic [1:0] gnt, done;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    int en_n = 0, up_n = 0, dn_n = 0, d0_n = 0, d1_n = 0;
    int s_en, s_up, s_dn, s_d0, s_d1;

    // model: phase 0 idle, 1 travelling, 2 reporting completion
    int m_phase = 0;
    int m_owner = 0;
    int m_rem   = 0;
    int m_pref  = 0;
    int m_cnt   = 0;
    bit m_dir   = 1'b1;

    cnt_seq_arb #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .tgt0     (tgt0),
        .tgt1     (tgt1),
        .cnt      (cnt_r),
        .en       (en),
        .up_dwn_n (up_dwn_n),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // External counter driven by the DUT, with a preload path for setup.
    always @(posedge clk) begin
        if (ld) cnt_r <= ld_val;
        else if (en) cnt_r <= up_dwn_n ? cnt_r + 4'd1 : cnt_r - 4'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_en = en_n; s_up = up_n; s_dn = dn_n; s_d0 = d0_n; s_d1 = d1_n;
    endtask

    task automatic load(input int v);
        ld = 1'b1;
        ld_val = 4'(v);
        tick();
        ld = 1'b0;
    endtask

    // Raise requests, drop each one when its done arrives; bounded.
    task automatic serve(input logic [1:0] r, output int gcyc, output int dcyc,
                         output logic [1:0] first_g);
        gcyc = -1; dcyc = -1; first_g = 2'b00;
        req = r;
        for (int c = 0; c < 40; c++) begin
            if (req == 2'b00) break;
            tick();
            if (gnt != 2'b00 && first_g == 2'b00) begin
                first_g = gnt;
                gcyc = c;
            end
            if (done != 2'b00 && dcyc < 0) dcyc = c;
            req = req & ~done;
        end
        chk("serve_timeout", int'(req == 2'b00), 1);
        req = 2'b00;
        tick();
        tick();
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic [1:0] eg, ed;
        logic ee, eu, eb;
        int g, t, du;
        eg = 2'b00; ed = 2'b00; ee = 1'b0; eu = 1'b1; eb = 1'b0;
        if (rst_n && m_phase != 0) begin
            eb = 1'b1;
            eg = (m_owner == 0) ? 2'b01 : 2'b10;
            if (m_phase == 2) ed = eg;
            if (m_phase == 1) begin
                ee = req[m_owner] && (m_rem > 0);
                eu = (m_rem == 0) ? 1'b1 : m_dir;
            end
        end
        if (chk_on) begin
            chk("gnt", int'(gnt), int'(eg));
            chk("done", int'(done), int'(ed));
            chk("en", int'(en), int'(ee));
            chk("up_dwn_n", int'(up_dwn_n), int'(eu));
            chk("busy", int'(busy), int'(eb));
            chk("cnt", int'(cnt_r), m_cnt);
        end
        en_n += int'(en);
        up_n += int'(en && up_dwn_n);
        dn_n += int'(en && !up_dwn_n);
        d0_n += int'(done[0]);
        d1_n += int'(done[1]);

        if (!rst_n) begin
            m_phase = 0;
            m_pref  = 0;
        end else begin
            case (m_phase)
                0: if (req != 2'b00) begin
                    g  = (req == 2'b11) ? m_pref : (req[1] ? 1 : 0);
                    t  = (g == 1) ? int'(tgt1) : int'(tgt0);
                    du = (t - m_cnt + 16) % 16;
                    m_owner = g;
                    if (du <= 8) begin m_dir = 1'b1; m_rem = du; end
                    else begin m_dir = 1'b0; m_rem = 16 - du; end
                    m_phase = 1;
                end
                1: if (!req[m_owner]) begin
                    m_phase = 0;
                    m_pref  = 1 - m_pref;
                end else if (m_rem > 0) begin
                    m_rem--;
                    m_cnt = m_dir ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
                end else begin
                    m_phase = 2;
                end
                default: begin
                    m_phase = 0;
                    m_pref  = 1 - m_owner;
                end
            endcase
        end
        if (ld) m_cnt = int'(ld_val);
    end

    initial begin
        int gc, dc;
        logic [1:0] fg, nr;

        rst_n = 1'b0; req = 2'b00; ld = 1'b1; ld_val = 4'd0;
        tick();
        chk_on = 1;
        tick(); tick();
        ld = 1'b0;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_up", int'(up_dwn_n), 1);
        rst_n = 1'b1;
        tick();

        // basic up move 0 -> 5
        tgt0 = 4'd5; snap();
        serve(2'b01, gc, dc, fg);
        chk("s1_first_gnt", int'(fg), 1);
        chk("s1_latency", dc - gc, 6);
        chk("s1_en_cycles", en_n - s_en, 5);
        chk("s1_up_steps", up_n - s_up, 5);
        chk("s1_cnt", int'(cnt_r), 5);
        chk("s1_done0", d0_n - s_d0, 1);
        chk("s1_gnt_after", int'(gnt), 0);

        // down path through wrap 3 -> 14
        load(3); tgt1 = 4'd14; snap();
        serve(2'b10, gc, dc, fg);
        chk("s2_first_gnt", int'(fg), 2);
        chk("s2_latency", dc - gc, 6);
        chk("s2_dn_steps", dn_n - s_dn, 5);
        chk("s2_en_cycles", en_n - s_en, 5);
        chk("s2_cnt", int'(cnt_r), 14);
        chk("s2_done1", d1_n - s_d1, 1);

        // simultaneous requests
        load(0); tgt0 = 4'd2; tgt1 = 4'd6; snap();
        serve(2'b11, gc, dc, fg);
        chk("s3_first_gnt", int'(fg), 1);
        chk("s3_latency0", dc - gc, 3);
        chk("s3_en_cycles", en_n - s_en, 6);
        chk("s3_cnt", int'(cnt_r), 6);
        chk("s3_done0", d0_n - s_d0, 1);
        chk("s3_done1", d1_n - s_d1, 1);

        // target already reached
        tgt0 = 4'd6; snap();
        serve(2'b01, gc, dc, fg);
        chk("s4_en_cycles", en_n - s_en, 0);
        chk("s4_latency", dc - gc, 1);
        chk("s4_done0", d0_n - s_d0, 1);

        // half-range ties count up
        load(0); tgt0 = 4'd8; snap();
        serve(2'b01, gc, dc, fg);
        chk("s5a_up_steps", up_n - s_up, 8);
        chk("s5a_latency", dc - gc, 9);
        chk("s5a_cnt", int'(cnt_r), 8);
        tgt0 = 4'd0; snap();
        serve(2'b01, gc, dc, fg);
        chk("s5b_up_steps", up_n - s_up, 8);
        chk("s5b_cnt", int'(cnt_r), 0);

        // serve requester 1 so the pointer rests on requester 0
        tgt1 = 4'd3;
        serve(2'b10, gc, dc, fg);
        chk("s5c_cnt", int'(cnt_r), 3);

        // abandon after two steps
        load(0); tgt0 = 4'd7; req = 2'b01;
        tick();
        chk("s6_gnt", int'(gnt), 1);
        tick(); tick();
        chk("s6_cnt_mid", int'(cnt_r), 2);
        snap();
        req = 2'b00;
        #1;
        chk("s6_abort_en", int'(en), 0);
        tick();
        chk("s6_cnt_hold", int'(cnt_r), 2);
        chk("s6_gnt_drop", int'(gnt), 0);
        tick();
        chk("s6_no_done", d0_n - s_d0, 0);
        tgt0 = 4'd1; tgt1 = 4'd9;
        serve(2'b11, gc, dc, fg);
        chk("s6_next_pref", int'(fg), 2);

        // asynchronous reset mid-move
        load(0); tgt0 = 4'd7; req = 2'b01;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("s7_en", int'(en), 0);
        chk("s7_up", int'(up_dwn_n), 1);
        chk("s7_gnt", int'(gnt), 0);
        chk("s7_done", int'(done), 0);
        chk("s7_busy", int'(busy), 0);
        req = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic with aborts, preloads and resets
        repeat (1500) begin
            ld = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; req = 2'b00;
                tick(); tick();
                rst_n = 1'b1;
            end
            tgt0 = 4'($urandom);
            tgt1 = 4'($urandom);
            if (req == 2'b00 && !busy && $urandom_range(0, 7) == 0) begin
                ld = 1'b1;
                ld_val = 4'($urandom);
            end else begin
                nr = req;
                for (int b = 0; b < 2; b++) begin
                    if (req[b] && done[b]) nr[b] = 1'b0;
                    else if (req[b] && gnt[b] && $urandom_range(0, 39) == 0) nr[b] = 1'b0;
                    else if (!req[b] && $urandom_range(0, 3) == 0) nr[b] = 1'b1;
                end
                req = nr;
            end
            tick();
        end
        ld = 1'b0; req = 2'b00;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
